// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the fetch path and its consumers.
//   - icode values I_HALT..I_POPQ and REG_NONE (no-register encoding)
//   - fetch_state_e : fetch unit state encoding
//   - len_info_t / instr_len() : instruction length and field presence per icode
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_OP,
        S_FETCH_REG,
        S_FETCH_CONST,
        S_HOLD,
        S_HALTED,
        S_ERROR
    } fetch_state_e;

    typedef struct packed {
        logic [3:0] len;
        logic       has_reg;
        logic       has_const;
    } len_info_t;

    // Undefined icodes decode as a 1-byte instruction with no fields.
    function automatic len_info_t instr_len(input logic [3:0] icode);
        len_info_t r;
        r.len       = 4'd1;
        r.has_reg   = 1'b0;
        r.has_const = 1'b0;
        case (icode)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                r.len     = 4'd2;
                r.has_reg = 1'b1;
            end
            I_JXX, I_CALL: begin
                r.len       = 4'd9;
                r.has_const = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                r.len       = 4'd10;
                r.has_reg   = 1'b1;
                r.has_const = 1'b1;
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational icode decoder: instruction length and presence of the
// register byte and 8-byte constant.
//   icode_i     : instruction code
//   len_o       : total length in bytes (1, 2, 9 or 10)
//   has_reg_o   : rA/rB byte follows the op byte
//   has_const_o : 8-byte little-endian constant follows
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode_i,
    output logic [3:0] len_o,
    output logic       has_reg_o,
    output logic       has_const_o
);

    len_info_t info;

    assign info        = instr_len(icode_i);
    assign len_o       = info.len;
    assign has_reg_o   = info.has_reg;
    assign has_const_o = info.has_const;

endmodule

// File: rtl/y86_fetch_unit.sv
// Y86-64 fetch stage: reads instruction bytes one at a time from a byte-wide
// memory at pc, assembles a full instruction and offers it with valid/ready.
// Optional feature macro: Y86_FETCH_ERR_EN (invalid icode -> ERROR state, err=1).
// Without it an invalid icode is delivered as a 1-byte nop and err stays 0.
//   clock, reset            : clock, synchronous active-high reset
//   mem_addr/mem_rd_en      : byte read request (address = pc + byte index)
//   mem_rdata/mem_rvalid    : returned byte; mem_rvalid=0 stalls the request
//   instr_valid/instr_ready : instruction handshake
//   icode/ifun/rA/rB/valC   : decoded fields (rA/rB=F, valC=0 when absent)
//   valP                    : address of next sequential instruction
//   pc_load/pc_load_value   : redirect, discards any partial instruction
//   halted/err              : halt retired / invalid icode seen
module y86_fetch_unit
    import y86_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [ADDR_W-1:0] valP,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_value,
    output logic              halted,
    output logic              err
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] valp_q;
    logic [ADDR_W-1:0] valp_d;
    logic [3:0]        off_q;     // byte index within the instruction
    logic [2:0]        cnt_q;     // constant byte index
    logic [3:0]        icode_q, ifun_q, ra_q, rb_q;
    logic [63:0]       valc_q;

    logic [3:0]        dec_icode;
    logic [3:0]        dec_len;
    logic              dec_has_reg;
    logic              dec_has_const;
    logic              bad_op;
    fetch_state_e      after_op;

    // While the op byte is on the bus decode it directly; afterwards decode
    // the latched icode so one decoder serves every state.
    assign dec_icode = (state_q == S_FETCH_OP) ? mem_rdata[7:4] : icode_q;

    y86_instr_len u_len (
        .icode_i     (dec_icode),
        .len_o       (dec_len),
        .has_reg_o   (dec_has_reg),
        .has_const_o (dec_has_const)
    );

    assign bad_op = (mem_rdata[7:4] > I_POPQ);
    assign valp_d = pc_q + ADDR_W'(dec_len);

    always_comb begin
        after_op = S_HOLD;
        if (dec_has_reg)
            after_op = S_FETCH_REG;
        else if (dec_has_const)
            after_op = S_FETCH_CONST;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            valp_q  <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            icode_q <= '0;
            ifun_q  <= '0;
            ra_q    <= REG_NONE;
            rb_q    <= REG_NONE;
            valc_q  <= '0;
        end else if (pc_load) begin
            // A coinciding handshake keeps its outputs; only the next fetch moves.
            state_q <= S_FETCH_OP;
            pc_q    <= pc_load_value;
            off_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_FETCH_OP;
                S_FETCH_OP: if (mem_rvalid) begin
                    icode_q <= mem_rdata[7:4];
                    ifun_q  <= mem_rdata[3:0];
                    ra_q    <= REG_NONE;
                    rb_q    <= REG_NONE;
                    valc_q  <= '0;
                    valp_q  <= valp_d;
                    off_q   <= 4'd1;
                    cnt_q   <= '0;
`ifdef Y86_FETCH_ERR_EN
                    state_q <= bad_op ? S_ERROR : after_op;
`else
                    state_q <= after_op;
                    if (bad_op) begin
                        icode_q <= I_NOP;
                        ifun_q  <= 4'h0;
                    end
`endif
                end
                S_FETCH_REG: if (mem_rvalid) begin
                    ra_q    <= mem_rdata[7:4];
                    rb_q    <= mem_rdata[3:0];
                    off_q   <= off_q + 4'd1;
                    state_q <= dec_has_const ? S_FETCH_CONST : S_HOLD;
                end
                S_FETCH_CONST: if (mem_rvalid) begin
                    valc_q[{cnt_q, 3'b000} +: 8] <= mem_rdata;
                    off_q <= off_q + 4'd1;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7)
                        state_q <= S_HOLD;
                end
                S_HOLD: if (instr_ready) begin
                    pc_q    <= valp_q;
                    off_q   <= '0;
                    state_q <= (icode_q == I_HALT) ? S_HALTED : S_FETCH_OP;
                end
                default: state_q <= state_q;   // HALTED/ERROR wait for pc_load
            endcase
        end
    end

    assign mem_addr    = pc_q + ADDR_W'(off_q);
    assign mem_rd_en   = (state_q == S_FETCH_OP) || (state_q == S_FETCH_REG) ||
                         (state_q == S_FETCH_CONST);
    assign instr_valid = (state_q == S_HOLD);
    assign halted      = (state_q == S_HALTED);
`ifdef Y86_FETCH_ERR_EN
    assign err         = (state_q == S_ERROR);
`else
    assign err         = 1'b0;
`endif
    assign icode       = icode_q;
    assign ifun        = ifun_q;
    assign rA          = ra_q;
    assign rB          = rb_q;
    assign valC        = valc_q;
    assign valP        = valp_q;

endmodule

// File: tb/tb_y86_fetch_unit.sv
module tb_y86_fetch_unit;

    logic        clock;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rdata;
    logic        rv;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC;
    logic [15:0] valP;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic        halted;
    logic        err;

    logic [7:0]  mem [0:65535];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc;
        logic [15:0] valp;
        int          lat;
    } exp_t;
    exp_t sb[$];

    y86_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_addr      (mem_addr),
        .mem_rd_en     (mem_rd_en),
        .mem_rdata     (mem_rdata),
        .mem_rvalid    (rv),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .icode         (icode),
        .ifun          (ifun),
        .rA            (rA),
        .rB            (rB),
        .valC          (valC),
        .valP          (valP),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .halted        (halted),
        .err           (err)
    );

    assign mem_rdata = mem[mem_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put8(input logic [15:0] a, input logic [7:0] b);
        mem[a] = b;
    endtask

    task automatic put64(input logic [15:0] a, input logic [63:0] v);
        for (int i = 0; i < 8; i++) mem[a + 16'(i)] = v[8*i +: 8];
    endtask

    task automatic expect_i(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                            input logic [3:0] rb, input logic [63:0] vc, input logic [15:0] vp,
                            input int lat);
        exp_t e;
        e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb; e.valc = vc; e.valp = vp; e.lat = lat;
        sb.push_back(e);
    endtask

    // Entered at a falling edge with the DUT in FETCH_OP on the first byte.
    // stall=1 withholds mem_rvalid on every other cycle.
    task automatic take(input int hold, input bit stall);
        exp_t        e;
        int          n;
        logic [15:0] a;
        n = 0;
        while (!instr_valid && n < 100) begin
            rv = stall ? ((n % 2) == 0) : 1'b1;
            a  = mem_addr;
            @(negedge clock);
            if (stall && !rv) chk("stall_addr_hold", 64'(mem_addr), 64'(a));
            n++;
        end
        rv = 1'b1;
        chk("valid_timeout", 64'(instr_valid), 64'd1);
        if (!instr_valid) return;
        chk("unexpected_valid", 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("icode", 64'(icode), 64'(e.icode));
        chk("ifun",  64'(ifun),  64'(e.ifun));
        chk("rA",    64'(rA),    64'(e.ra));
        chk("rB",    64'(rB),    64'(e.rb));
        chk("valC",  valC,       e.valc);
        chk("valP",  64'(valP),  64'(e.valp));
        chk("latency", 64'(n),   64'(e.lat));
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk("hold_valid", 64'(instr_valid), 64'd1);
            chk("hold_rd_en", 64'(mem_rd_en),   64'd0);
            chk("hold_icode", 64'(icode),       64'(e.icode));
            chk("hold_rA",    64'(rA),          64'(e.ra));
            chk("hold_rB",    64'(rB),          64'(e.rb));
            chk("hold_valP",  64'(valP),        64'(e.valp));
        end
        instr_ready = 1'b1;
        @(negedge clock);
        instr_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rv = 1'b1; instr_ready = 1'b0; pc_load = 1'b0; pc_load_value = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h10;

        // program image
        put8(16'h0000, 8'h10);                                        // nop
        put8(16'h0001, 8'h30); put8(16'h0002, 8'hF0);                 // irmovq
        put64(16'h0003, 64'h0123456789ABCDEF);
        put8(16'h000B, 8'h60); put8(16'h000C, 8'h12);                 // OPq
        put8(16'h000D, 8'h21); put8(16'h000E, 8'h3A);                 // cmovle
        put8(16'h000F, 8'h90);                                        // ret
        put8(16'h0010, 8'h80); put64(16'h0011, 64'h1122334455667788); // call
        put8(16'h0019, 8'h30); put8(16'h001A, 8'hF3);                 // irmovq, redirected away
        put64(16'h001B, 64'hDEADBEEFCAFEF00D);
        put8(16'h0040, 8'hC0);                                        // invalid
        put8(16'h0041, 8'h00);                                        // halt

        // reset state
        @(negedge clock); @(negedge clock);
        chk("rst_valid",  64'(instr_valid), 64'd0);
        chk("rst_rd_en",  64'(mem_rd_en),   64'd0);
        chk("rst_halted", 64'(halted),      64'd0);
        chk("rst_err",    64'(err),         64'd0);
        chk("rst_icode",  64'(icode),       64'd0);
        chk("rst_rA",     64'(rA),          64'hF);
        chk("rst_rB",     64'(rB),          64'hF);
        chk("rst_valC",   valC,             64'd0);
        chk("rst_valP",   64'(valP),        64'd0);
        chk("rst_addr",   64'(mem_addr),    64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("fetch_rd_en", 64'(mem_rd_en), 64'd1);
        chk("fetch_addr",  64'(mem_addr),  64'd0);

        expect_i(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 16'h0001, 1);
        take(0, 1'b0);
        expect_i(4'h3, 4'h0, 4'hF, 4'h0, 64'h0123456789ABCDEF, 16'h000B, 10);
        take(0, 1'b0);
        expect_i(4'h6, 4'h0, 4'h1, 4'h2, 64'd0, 16'h000D, 2);
        take(5, 1'b0);
        expect_i(4'h2, 4'h1, 4'h3, 4'hA, 64'd0, 16'h000F, 2);
        take(0, 1'b0);
        expect_i(4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 16'h0010, 1);
        take(0, 1'b0);
        expect_i(4'h8, 4'h0, 4'hF, 4'hF, 64'h1122334455667788, 16'h0019, 17);
        take(0, 1'b1);

        // redirect while the 4th irmovq byte is pending
        @(negedge clock); @(negedge clock); @(negedge clock);
        chk("redir_pending_addr", 64'(mem_addr), 64'h001C);
        pc_load = 1'b1; pc_load_value = 16'h0040;
        @(negedge clock);
        pc_load = 1'b0;
        chk("redir_no_valid", 64'(instr_valid), 64'd0);
        chk("redir_addr",     64'(mem_addr),    64'h0040);
        chk("redir_rd_en",    64'(mem_rd_en),   64'd1);

`ifdef Y86_FETCH_ERR_EN
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            chk("err_set",      64'(err),         64'd1);
            chk("err_no_valid", 64'(instr_valid), 64'd0);
            chk("err_rd_en",    64'(mem_rd_en),   64'd0);
            @(negedge clock);
        end
        pc_load = 1'b1; pc_load_value = 16'h0041;
        @(negedge clock);
        pc_load = 1'b0;
        chk("err_cleared", 64'(err),      64'd0);
        chk("err_redir",   64'(mem_addr), 64'h0041);
`else
        expect_i(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 16'h0041, 1);
        take(0, 1'b0);
        chk("err_tied", 64'(err), 64'd0);
`endif

        expect_i(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 16'h0042, 1);
        take(0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk("halted",       64'(halted),      64'd1);
            chk("halt_rd_en",   64'(mem_rd_en),   64'd0);
            chk("halt_novalid", 64'(instr_valid), 64'd0);
            @(negedge clock);
        end
        pc_load = 1'b1; pc_load_value = 16'h0010;
        @(negedge clock);
        pc_load = 1'b0;
        chk("resume_halted", 64'(halted),    64'd0);
        chk("resume_addr",   64'(mem_addr),  64'h0010);
        chk("resume_rd_en",  64'(mem_rd_en), 64'd1);
        expect_i(4'h8, 4'h0, 4'hF, 4'hF, 64'h1122334455667788, 16'h0019, 9);
        take(0, 1'b0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
